// File: rtl/io_pkg.sv
// Shared IO-window constants used by the input reader and the output writer.
package io_pkg;

  localparam int IO_PORT_W = 32;

  localparam logic [5:0] IO_ADDR_PORT0  = 6'b100000;
  localparam logic [5:0] IO_ADDR_PORT1  = 6'b100001;
  localparam logic [5:0] IO_ADDR_PORT2  = 6'b100010;
  localparam logic [5:0] IO_ADDR_STATUS = 6'b100011;

  // STATUS word layout: change flags in the low bits, upper bits read as zero.
  function automatic logic [IO_PORT_W-1:0] io_status_word(input logic [2:0] chg);
    return {29'b0, chg};
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One input port: 2-flop synchroniser followed by a whole-word debouncer.
module io_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic                 io_clk,
  input  logic                 reset,
  input  logic [IO_PORT_W-1:0] i_raw,
  output logic [IO_PORT_W-1:0] o_stable,
  output logic                 o_accept
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [IO_PORT_W-1:0] r_meta;
  logic [IO_PORT_W-1:0] r_sync;
  logic [IO_PORT_W-1:0] r_stable;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_differs;
  logic                 w_accept;

  assign w_differs = (r_sync != r_stable);
  // Acceptance fires on the edge where the count would reach DEBOUNCE_CYCLES.
  assign w_accept  = w_differs && (r_cnt == LP_LAST);

  // Synchroniser, debounce counter and accepted value.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      r_meta   <= {IO_PORT_W{1'b0}};
      r_sync   <= {IO_PORT_W{1'b0}};
      r_stable <= {IO_PORT_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (!w_differs) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (w_accept) begin
        r_stable <= r_sync;
        r_cnt    <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_stable = r_stable;
  assign o_accept = w_accept;

endmodule

// File: rtl/io_input_reader.sv
// Memory-mapped reader for three debounced input ports with sticky change flags and IRQ.
module io_input_reader
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic                 io_clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic                 read_io_enable,
  input  logic [IO_PORT_W-1:0] in_port0,
  input  logic [IO_PORT_W-1:0] in_port1,
  input  logic [IO_PORT_W-1:0] in_port2,
  output logic [31:0]          dataout,
  output logic                 irq
);

  logic [IO_PORT_W-1:0] w_stable0;
  logic [IO_PORT_W-1:0] w_stable1;
  logic [IO_PORT_W-1:0] w_stable2;
  logic [2:0]           w_accept;
  logic [2:0]           w_chg_next;
  logic [2:0]           r_chg;
  logic [5:0]           w_word;
  logic                 w_status_rd;
  logic [31:0]          w_rdata;
  logic                 w_unused_addr;

  io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db0 (
    .io_clk(io_clk), .reset(reset), .i_raw(in_port0), .o_stable(w_stable0), .o_accept(w_accept[0])
  );
  io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db1 (
    .io_clk(io_clk), .reset(reset), .i_raw(in_port1), .o_stable(w_stable1), .o_accept(w_accept[1])
  );
  io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db2 (
    .io_clk(io_clk), .reset(reset), .i_raw(in_port2), .o_stable(w_stable2), .o_accept(w_accept[2])
  );

  assign w_word        = addr[7:2];
  assign w_unused_addr = ^{addr[31:8], addr[1:0]};

  // Read mux over the decoded word address.
  always_comb begin
    w_rdata = 32'h0;
    case (w_word)
      IO_ADDR_PORT0:  w_rdata = w_stable0;
      IO_ADDR_PORT1:  w_rdata = w_stable1;
      IO_ADDR_PORT2:  w_rdata = w_stable2;
      IO_ADDR_STATUS: w_rdata = io_status_word(r_chg);
      default:        w_rdata = 32'h0;
    endcase
  end

  // A same-edge acceptance wins over the read-to-clear of its flag.
  assign w_status_rd = read_io_enable && (w_word == IO_ADDR_STATUS);
  assign w_chg_next  = (w_status_rd ? 3'b000 : r_chg) | w_accept;

  // Change flags, interrupt and registered read data.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      r_chg   <= 3'b000;
      irq     <= 1'b0;
      dataout <= 32'h0;
    end else begin
      r_chg <= w_chg_next;
      irq   <= |w_chg_next;
      if (read_io_enable) begin
        dataout <= w_rdata;
      end
    end
  end

endmodule
